// File: rtl/hidden_backprop.sv
// hidden_backprop
//   Backward pass for one hidden neuron: trains its XW input-to-hidden
//   weights. A pass captures the output error, this neuron's output-layer
//   weight, its forward activation and the forward inputs. It forms
//   delta = err * w_out, gated by ReLU so that delta is 0 when the
//   activation is 0. It then walks the weights, one per cycle, applying
//   w[k] -= delta >>> LR_SHIFT wherever x[k] = 1.
//
// Configuration macro: HB_SAT_EN
//   defined   : weight updates saturate to the signed WW-bit range
//   undefined : weight updates wrap (low WW bits kept)
//
// Ports
//   clk_i                clock
//   rst_i                asynchronous reset, active-low
//   en_i                 pass request (level); one pass per high level
//   zero_weight_reset_i  load w_init_i, abort any pass (highest priority)
//   err_i                signed output error
//   w_out_i              signed output-layer weight of this neuron
//   hidden_val_i         forward activation (post-ReLU, unsigned)
//   x_i                  forward inputs, bit k pairs with weight k
//   w_init_i             initial weights, weight k at [k*WW +: WW]
//   w_o                  current weights, same packing as w_init_i
//   busy_o               high while a pass is in progress
//   b_end_o              one-cycle pulse when a pass completes
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for en_i; captures the inputs when it is seen
// CAPT  | forms the gated delta from the captured copies
// UPD   | updates weight k_r, k_r = 0..XW-1
// DONE  | pass complete; b_end_o is raised for one cycle
// WAIT  | holds until en_i drops so a held request is not re-run
module hidden_backprop #(
  parameter int XW       = 4,
  parameter int HW       = 10,
  parameter int WW       = 8,
  parameter int EW       = 23,
  parameter int LR_SHIFT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 zero_weight_reset_i,
  input  logic [EW-1:0]        err_i,
  input  logic [WW-1:0]        w_out_i,
  input  logic [HW-1:0]        hidden_val_i,
  input  logic [XW-1:0]        x_i,
  input  logic [XW*WW-1:0]     w_init_i,
  output logic [XW*WW-1:0]     w_o,
  output logic                 busy_o,
  output logic                 b_end_o
);

  localparam int PW = EW + WW;
  localparam int KW = (XW > 1) ? $clog2(XW) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(XW - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAPT = 3'd1,
    UPD  = 3'd2,
    DONE = 3'd3,
    WAIT = 3'd4
  } state_t;

  state_t state;

  logic signed [EW-1:0] err_r;
  logic signed [WW-1:0] w_out_r;
  logic [HW-1:0]        hid_r;
  logic [XW-1:0]        x_r;
  logic signed [PW-1:0] delta_r;
  logic [KW-1:0]        k_r;
  logic signed [WW-1:0] w_r [XW];

  logic signed [PW-1:0] step;
  logic signed [WW-1:0] w_cur;
  // One extra bit so w - step can never overflow before fit().
  logic signed [PW:0]   diff;
  logic signed [WW-1:0] w_fit;

  assign step  = delta_r >>> LR_SHIFT;
  assign w_cur = w_r[k_r];
  assign diff  = (PW+1)'(w_cur) - (PW+1)'(step);

`ifdef HB_SAT_EN
  logic in_range;

  // In range when every bit from the WW-bit sign position upward agrees.
  always_comb begin
    in_range = (diff[PW:WW-1] == '0) || (&diff[PW:WW-1]);
    w_fit    = diff[WW-1:0];
    if (!in_range) begin
      w_fit = diff[PW] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
    end
  end
`else
  logic unused_diff;

  assign w_fit       = diff[WW-1:0];
  assign unused_diff = ^diff[PW:WW];
`endif

  always_comb begin
    w_o = '0;
    for (int i = 0; i < XW; i++) begin
      w_o[i*WW +: WW] = w_r[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      err_r   <= '0;
      w_out_r <= '0;
      hid_r   <= '0;
      x_r     <= '0;
      delta_r <= '0;
      k_r     <= '0;
      busy_o  <= 1'b0;
      b_end_o <= 1'b0;
      for (int i = 0; i < XW; i++) begin
        w_r[i] <= '0;
      end
    end else if (zero_weight_reset_i) begin
      state   <= IDLE;
      delta_r <= '0;
      k_r     <= '0;
      busy_o  <= 1'b0;
      b_end_o <= 1'b0;
      for (int i = 0; i < XW; i++) begin
        w_r[i] <= w_init_i[i*WW +: WW];
      end
    end else begin
      b_end_o <= 1'b0;
      case (state)
        IDLE: begin
          if (en_i) begin
            err_r   <= err_i;
            w_out_r <= w_out_i;
            hid_r   <= hidden_val_i;
            x_r     <= x_i;
            busy_o  <= 1'b1;
            state   <= CAPT;
          end
        end
        CAPT: begin
          // ReLU derivative: a zero activation passes no gradient.
          delta_r <= (hid_r != '0) ? (PW'(err_r) * PW'(w_out_r)) : '0;
          k_r     <= '0;
          state   <= UPD;
        end
        UPD: begin
          if (x_r[k_r]) begin
            w_r[k_r] <= w_fit;
          end
          if (k_r == K_LAST) begin
            state <= DONE;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        DONE: begin
          b_end_o <= 1'b1;
          busy_o  <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (!en_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
